// File: rtl/msrh_conf_pkg.sv
// Core-wide configuration constants shared by every msrh block.
package msrh_conf_pkg;
  localparam int BR_TAG_NUM    = 8;
  localparam int DISP_BR_WIDTH = 2;
endpackage

// File: rtl/msrh_pkg.sv
// Common msrh types; brmask_t is the branch mask seen by the schedulers and the BRU pipe.
package msrh_pkg;
  localparam int BRTAG_NUM         = msrh_conf_pkg::BR_TAG_NUM;
  localparam int BRTAG_ALLOC_WIDTH = msrh_conf_pkg::DISP_BR_WIDTH;

  typedef logic [BRTAG_NUM-1:0] brmask_t;
endpackage

// File: rtl/msrh_brtag_alloc_if.sv
// Dispatch / branch-resolve / flush bundle of the branch tag allocator.
interface msrh_brtag_alloc_if #(
  parameter int TAG_NUM     = 8,
  parameter int ALLOC_WIDTH = 2
);
  localparam int CNT_W = $clog2(TAG_NUM + 1);

  logic                                  i_alloc_valid;
  logic [ALLOC_WIDTH-1:0]                i_alloc_req;
  logic                                  o_alloc_ready;
  logic [ALLOC_WIDTH-1:0][TAG_NUM-1:0]   o_alloc_tag_oh;
  logic                                  i_resolve_valid;
  logic [TAG_NUM-1:0]                    i_resolve_tag_oh;
  logic                                  i_resolve_mispred;
  logic                                  i_flush;
  logic [TAG_NUM-1:0]                    o_active_mask;
  logic [TAG_NUM-1:0]                    o_kill_mask;
  logic [CNT_W-1:0]                      o_free_count;

  modport master (
    output i_alloc_valid, i_alloc_req, i_resolve_valid, i_resolve_tag_oh,
           i_resolve_mispred, i_flush,
    input  o_alloc_ready, o_alloc_tag_oh, o_active_mask, o_kill_mask, o_free_count
  );

  modport slave (
    input  i_alloc_valid, i_alloc_req, i_resolve_valid, i_resolve_tag_oh,
           i_resolve_mispred, i_flush,
    output o_alloc_ready, o_alloc_tag_oh, o_active_mask, o_kill_mask, o_free_count
  );
endinterface

// File: rtl/msrh_brtag_pick.sv
// Find-first-N-free picker: each requesting slot, oldest first, takes the lowest
// free tag not already taken by an older slot.
module msrh_brtag_pick #(
  parameter int TAG_NUM     = 8,
  parameter int ALLOC_WIDTH = 2
) (
  input  logic [TAG_NUM-1:0]                  free_vec,
  input  logic [ALLOC_WIDTH-1:0]              req,
  output logic [ALLOC_WIDTH-1:0][TAG_NUM-1:0] pick_oh
);
  logic [TAG_NUM-1:0] avail [ALLOC_WIDTH];

  assign avail[0] = free_vec;

  generate
    for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_slot
      // a & (~a + 1) isolates the lowest set bit
      assign pick_oh[gi] = req[gi] ? (avail[gi] & (~avail[gi] + TAG_NUM'(1))) : '0;
      if (gi < ALLOC_WIDTH - 1) begin : g_chain
        assign avail[gi+1] = avail[gi] & ~pick_oh[gi];
      end
    end
  endgenerate
endmodule

// File: rtl/msrh_brtag_alloc.sv
// Branch tag allocator: grants one-hot tags to dispatched branches, tracks
// which older branches each tag depends on, and produces kill masks on mispredict.
module msrh_brtag_alloc
  import msrh_pkg::*;
#(
  parameter int TAG_NUM     = BRTAG_NUM,
  parameter int ALLOC_WIDTH = BRTAG_ALLOC_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  msrh_brtag_alloc_if.slave br_if
);
  localparam int CNT_W = $clog2(TAG_NUM + 1);

  logic [TAG_NUM-1:0]                 active_reg, active_next;
  logic [TAG_NUM-1:0]                 dep_reg  [TAG_NUM];
  logic [TAG_NUM-1:0]                 dep_next [TAG_NUM];
  logic [TAG_NUM-1:0]                 younger, freed, grant_acc;
  logic [ALLOC_WIDTH-1:0][TAG_NUM-1:0] pick_oh;
  logic [CNT_W-1:0]                   act_cnt, req_cnt, free_cnt;
  logic                               resolve_hit, mispred_now, ready, fire;

  msrh_brtag_pick #(.TAG_NUM(TAG_NUM), .ALLOC_WIDTH(ALLOC_WIDTH)) u_pick (
    .free_vec (~active_reg),
    .req      (br_if.i_alloc_req),
    .pick_oh  (pick_oh)
  );

  generate
    for (genvar gi = 0; gi < TAG_NUM; gi++) begin : g_tag
      assign younger[gi] = active_reg[gi] & |(dep_reg[gi] & br_if.i_resolve_tag_oh);

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) dep_reg[gi] <= '0;
        else            dep_reg[gi] <= dep_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) active_reg <= '0;
    else            active_reg <= active_next;
  end

  always_comb begin
    act_cnt = '0;
    for (int i = 0; i < TAG_NUM; i++) act_cnt += CNT_W'(active_reg[i]);
    req_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) req_cnt += CNT_W'(br_if.i_alloc_req[i]);
  end

  assign free_cnt    = CNT_W'(TAG_NUM) - act_cnt;
  // Resolves against tags that are not in flight are stale and ignored
  assign resolve_hit = br_if.i_resolve_valid && |(br_if.i_resolve_tag_oh & active_reg);
  assign mispred_now = resolve_hit && br_if.i_resolve_mispred;
  assign ready       = !i_reset_n ||
                       ((free_cnt >= req_cnt) && !br_if.i_flush && !mispred_now);
  assign fire        = br_if.i_alloc_valid && ready;

  always_comb begin
    freed = '0;
    if (br_if.i_flush)
      freed = '1;
    else if (resolve_hit)
      freed = (br_if.i_resolve_tag_oh & active_reg) | (mispred_now ? younger : '0);
  end

  // Rows of freed tags clear; columns of freed tags drop out of surviving rows.
  // A new tag depends on survivors plus tags given to older slots this cycle.
  always_comb begin
    grant_acc = '0;
    for (int t = 0; t < TAG_NUM; t++)
      dep_next[t] = freed[t] ? '0 : (dep_reg[t] & ~freed);
    if (fire) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        for (int t = 0; t < TAG_NUM; t++)
          if (pick_oh[k][t]) dep_next[t] = (active_reg & ~freed) | grant_acc;
        grant_acc |= pick_oh[k];
      end
    end
    active_next = (active_reg & ~freed) | grant_acc;
  end

  assign br_if.o_alloc_ready  = ready;
  assign br_if.o_alloc_tag_oh = fire ? pick_oh : '0;
  assign br_if.o_active_mask  = active_reg;
  assign br_if.o_kill_mask    = br_if.i_flush ? active_reg : (mispred_now ? younger : '0);
  assign br_if.o_free_count   = free_cnt;
endmodule
